// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results for MEM and loops the
// two-cycle MADD/MSUB intermediate back to EX while EX is stalled.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                ex_wreg,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic                mem_wreg,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o
);

  typedef enum logic [1:0] {
    ACT_NOP,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADVANCE
  } action_t;

  action_t action;

  // Only the EX and MEM stall bits matter to this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // Flush beats MEM stall, which beats EX stall; an illegal
  // stall[4]=1/stall[3]=0 combination therefore resolves to hold.
  always_comb begin
    action = ACT_ADVANCE;
    if (flush) begin
      action = ACT_NOP;
    end else if (stall[4]) begin
      action = ACT_HOLD;
    end else if (stall[3]) begin
      action = ACT_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || action == ACT_NOP) begin
      mem_wreg  <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else begin
      case (action)
        ACT_HOLD: begin
          hilo_o <= hilo_i;
          cnt_o  <= cnt_i;
        end
        ACT_BUBBLE: begin
          // NOP into MEM while the MADD/MSUB first-cycle product is kept.
          mem_wreg  <= 1'b0;
          mem_waddr <= '0;
          mem_wdata <= '0;
          mem_whilo <= 1'b0;
          mem_hi    <= '0;
          mem_lo    <= '0;
          hilo_o    <= hilo_i;
          cnt_o     <= cnt_i;
        end
        default: begin
          mem_wreg  <= ex_wreg;
          mem_waddr <= ex_waddr;
          mem_wdata <= ex_wdata;
          mem_whilo <= ex_whilo;
          mem_hi    <= ex_hi;
          mem_lo    <= ex_lo;
          hilo_o    <= '0;
          cnt_o     <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures the EX results on each rising edge: GPR write request, HI/LO write request and data.
- Presents the captured values to MEM unchanged.
- Supports stall, bubble insertion and flush.
- Holds the two-cycle MADD/MSUB intermediate (hilo_temp and cycle counter) and feeds it back to EX while the pipeline is stalled.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data words.
- ADDR_W, 5, width of GPR write address.
- CNT_W, 2, width of multi-cycle op counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low; rst==0 at a rising edge resets all state.
- stall  in  6  pipeline stall vector from the stall controller; bit3 = EX stalled, bit4 = MEM stalled.
- flush  in  1  exception flush; clears the register to a NOP.
- ex_wreg  in  1  EX GPR write enable.
- ex_waddr  in  ADDR_W  EX GPR write address.
- ex_wdata  in  DATA_W  EX GPR write data.
- ex_whilo  in  1  EX HI/LO write enable.
- ex_hi  in  DATA_W  EX HI value.
- ex_lo  in  DATA_W  EX LO value.
- hilo_i  in  2*DATA_W  EX MADD/MSUB intermediate product.
- cnt_i  in  CNT_W  EX multi-cycle op counter.
- mem_wreg  out  1  registered GPR write enable to MEM.
- mem_waddr  out  ADDR_W  registered GPR write address.
- mem_wdata  out  DATA_W  registered GPR write data.
- mem_whilo  out  1  registered HI/LO write enable.
- mem_hi  out  DATA_W  registered HI value.
- mem_lo  out  DATA_W  registered LO value.
- hilo_o  out  2*DATA_W  intermediate fed back to EX.
- cnt_o  out  CNT_W  counter fed back to EX.

Behaviour:
- All outputs are flops. No combinational path from any input to any output; latency is exactly 1 cycle.
- Reset (rst==0 at an edge):
  - mem_wreg=0, mem_waddr=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0, hilo_o=0, cnt_o=0.
  - Reset takes priority over every other input, including a reset asserted mid MADD/MSUB, which discards the intermediate.
- Evaluation order at each rising edge with rst==1, first match wins:
  1. flush==1 → NOP: all mem_* outputs = 0, hilo_o = 0, cnt_o = 0. Flush overrides stall.
  2. stall[4]==1 (MEM stalled) → hold: all mem_* outputs keep their values; hilo_o<=hilo_i, cnt_o<=cnt_i.
  3. stall[3]==1, stall[4]==0 (EX stalled, MEM free) → bubble: all mem_* outputs = 0 (NOP into MEM); hilo_o<=hilo_i, cnt_o<=cnt_i. This keeps the first-cycle MADD/MSUB product for EX's second cycle.
  4. stall[3]==0 → advance: mem_*<=ex_*; hilo_o = 0, cnt_o = 0.
- The stall controller never drives stall[3]=0 with stall[4]=1. If it does, rule 2 applies (hold).
- stall bits other than 3 and 4 are ignored.
- A NOP is defined as: write enables 0, address 0, all data 0. MEM must see no GPR or HI/LO write in a bubble or flush cycle.
- No width conversion. Values pass bit-exact.
- The MADD/MSUB sequence, as seen at this block:
  - Cycle N: EX asserts stall[3] with cnt_i=1 and hilo_i=product, so the block bubbles and captures both.
  - Cycle N+1: EX reads hilo_o/cnt_o, completes, and deasserts the stall, so the block advances the final HI/LO and clears hilo_o/cnt_o.

Test Plan:
- Reset: drive all inputs non-zero and rst=0 for one edge → every output 0 the following cycle. Release rst → no change until stall[3]=0 with new inputs.
- Advance: stall=0, ex_wreg=1, ex_waddr=5'd3, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hAAAA_0000, ex_lo=32'h0000_5555 → identical values on mem_* one edge later; hilo_o=0, cnt_o=0.
- Bubble: stall=6'b001111, ex_wdata=32'hDEAD_BEEF, hilo_i=64'h1_0000_0002, cnt_i=1 → mem_wreg=0, mem_wdata=0, mem_whilo=0; hilo_o=64'h1_0000_0002, cnt_o=1.
- Hold: after an advance of wdata=32'hCAFE_F00D, apply stall=6'b011111 for 3 cycles with changing ex_* inputs → mem_wdata stays 32'hCAFE_F00D, and hilo_o/cnt_o track hilo_i/cnt_i each cycle.
- Flush over stall: stall=6'b011111 and flush=1 with mem_wreg=1 held → next cycle all mem_* = 0, hilo_o=0, cnt_o=0.
- MADD sequence: bubble cycle capturing hilo_i=64'h0000_0003_0000_0004, cnt_i=1, then stall=0 with ex_hi=32'h5, ex_lo=32'h9, ex_whilo=1 → mem_hi=5, mem_lo=9, mem_whilo=1, hilo_o=0, cnt_o=0.
